// File: rtl/capture_pkg.sv
// capture_pkg: shared types and constants for the capture buffer.
//   cap_state_e : capture state machine encoding
//   depth_f()   : RAM depth derived from the address width
//   *_RST       : reset values of the architectural registers
package capture_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRETRIG,
      ARMED,
      POST,
      DONE
   } cap_state_e;

   function automatic int depth_f(input int aw);
      return 1 << aw;
   endfunction

   localparam cap_state_e ST_RST   = IDLE;
   localparam logic       BUSY_RST = 1'b0;
   localparam logic       DONE_RST = 1'b0;

endpackage

// File: rtl/ram2ports_wr.sv
// ram2ports_wr: simple dual-port RAM, one synchronous write port and one
// synchronous read port (1-cycle latency). A read of the address being
// written in the same cycle returns the old contents.
//   clk, rst_n   : clock, synchronous active-low reset (read register only)
//   we/waddr/wdata : write port
//   raddr/rdata  : read port, rdata registered
module ram2ports_wr #(
   parameter int ADDRESS_WIDTH = 8,
   parameter int DATA_WIDTH    = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     we,
   input  logic [ADDRESS_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0]    wdata,
   input  logic [ADDRESS_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0]    rdata
);

   logic [DATA_WIDTH-1:0] mem [2**ADDRESS_WIDTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   // Storage is never reset.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) rdata_q <= '0;
      else        rdata_q <= mem[raddr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/capture_ram_writer.sv
// capture_ram_writer: triggered sample-capture buffer. After arm, samples
// stream into a circular RAM; once PRE_TRIG samples are held, a trigger
// selects the trigger sample and the window closes DEPTH samples after its
// first (oldest) sample. The read port is addressed relative to that sample.
//   clk, rst_n          : clock, synchronous active-low reset
//   arm                 : start capture (ignored while busy)
//   trigger             : trigger level, sampled per cycle
//   din_valid, din      : sample stream
//   decim               : keep every (decim+1)th sample (CAPTURE_DECIM_EN only)
//   busy, done          : registered status
//   start_addr          : physical address of window sample 0
//   rd_addr, rd_dout    : logical read index, registered read data
// Optional feature macro: CAPTURE_DECIM_EN.
module capture_ram_writer
   import capture_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 8,
   parameter int DATA_WIDTH    = 8,
   parameter int PRE_TRIG      = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     arm,
   input  logic                     trigger,
   input  logic                     din_valid,
   input  logic [DATA_WIDTH-1:0]    din,
`ifdef CAPTURE_DECIM_EN
   input  logic [3:0]               decim,
`endif
   output logic                     busy,
   output logic                     done,
   output logic [ADDRESS_WIDTH-1:0] start_addr,
   input  logic [ADDRESS_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0]    rd_dout
);

   localparam int DEPTH = depth_f(ADDRESS_WIDTH);
   localparam logic [ADDRESS_WIDTH-1:0] PRE_A  = ADDRESS_WIDTH'(PRE_TRIG);
   // Samples still to come after the trigger sample.
   localparam logic [ADDRESS_WIDTH-1:0] POST_A = ADDRESS_WIDTH'(DEPTH - PRE_TRIG - 1);

   cap_state_e                 state_q, state_d;
   logic [ADDRESS_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDRESS_WIDTH-1:0]   fill_q, fill_d;
   logic [ADDRESS_WIDTH-1:0]   post_q, post_d;
   logic [ADDRESS_WIDTH-1:0]   start_q, start_d;
   logic                       pend_q, pend_d;
   logic                       busy_q, done_q;
   logic                       we;
   logic                       keep;
   logic                       trig_hit;

   // A pending trigger turns the next valid sample into the trigger sample.
   assign trig_hit = (state_q == ARMED) && din_valid && (trigger || pend_q);

`ifdef CAPTURE_DECIM_EN
   logic [3:0] dec_q;
   logic       capturing;

   assign capturing = (state_q == PRETRIG) || (state_q == ARMED) || (state_q == POST);
   assign keep      = (dec_q == 4'd0);

   // The trigger sample is stored unconditionally and counts as slot 0.
   always_ff @(posedge clk) begin
      if (!rst_n)                                      dec_q <= '0;
      else if ((state_q == IDLE || state_q == DONE) && arm) dec_q <= '0;
      else if (trig_hit)                               dec_q <= (decim == 4'd0) ? 4'd0 : 4'd1;
      else if (capturing && din_valid)                 dec_q <= (dec_q >= decim) ? 4'd0 : dec_q + 4'd1;
   end
`else
   assign keep = 1'b1;
`endif

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      fill_d   = fill_q;
      post_d   = post_q;
      start_d  = start_q;
      pend_d   = pend_q;
      we       = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (arm) begin
               state_d  = PRETRIG;
               wr_ptr_d = '0;
               fill_d   = '0;
               pend_d   = 1'b0;
            end
         end
         PRETRIG: begin
            if (din_valid && keep) begin
               we       = 1'b1;
               wr_ptr_d = wr_ptr_q + 1'b1;
               fill_d   = fill_q + 1'b1;
               if (fill_q + 1'b1 == PRE_A) state_d = ARMED;
            end
         end
         ARMED: begin
            if (trig_hit) begin
               we       = 1'b1;
               wr_ptr_d = wr_ptr_q + 1'b1;
               pend_d   = 1'b0;
               start_d  = wr_ptr_q - PRE_A;
               post_d   = POST_A;
               state_d  = (POST_A == '0) ? DONE : POST;
            end else if (!din_valid) begin
               pend_d = pend_q | trigger;
            end else if (keep) begin
               we       = 1'b1;
               wr_ptr_d = wr_ptr_q + 1'b1;
            end
         end
         POST: begin
            if (din_valid && keep) begin
               we       = 1'b1;
               wr_ptr_d = wr_ptr_q + 1'b1;
               post_d   = post_q - 1'b1;
               if (post_q == ADDRESS_WIDTH'(1)) state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_RST;
         wr_ptr_q <= '0;
         fill_q   <= '0;
         post_q   <= '0;
         start_q  <= '0;
         pend_q   <= 1'b0;
         busy_q   <= BUSY_RST;
         done_q   <= DONE_RST;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         fill_q   <= fill_d;
         post_q   <= post_d;
         start_q  <= start_d;
         pend_q   <= pend_d;
         busy_q   <= (state_d == PRETRIG) || (state_d == ARMED) || (state_d == POST);
         done_q   <= (state_d == DONE);
      end
   end

   ram2ports_wr #(
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .DATA_WIDTH    (DATA_WIDTH)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we),
      .waddr (wr_ptr_q),
      .wdata (din),
      .raddr (start_q + rd_addr),
      .rdata (rd_dout)
   );

   assign busy       = busy_q;
   assign done       = done_q;
   assign start_addr = start_q;

endmodule
